dm_access_unit: RTL and testbench

// - Load/store unit between the CPU memory stage and the data-memory SRAM_wrapper. Sits directly upstream of DM.
// - Accepts one byte/half/word request per handshake and drives the SRAM WEB/BWEB/A/DI from registers.
// - Captures DO one cycle after the read issue, then lane-selects and sign/zero-extends it.
// - Returns one response, with an error flag, per accepted request.

---
 rtl/dm_access_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// ============================================================================
// Module   : dm_access_unit
// Purpose  : Load/store unit between the CPU memory stage and the data SRAM.
//            Optional macro MISALIGN_SPLIT_EN splits misaligned half/word
//            accesses into two SRAM accesses to consecutive words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_access_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              dm_web,
    output logic [DATA_W-1:0] dm_bweb,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_data_in,
    input  logic [DATA_W-1:0] dm_data_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_ISSUE1 = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d, uns_q, uns_d;
    logic [1:0]          size_q, size_d, off_q, off_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                dm_web_q, dm_web_d;
    logic [DATA_W-1:0]   dm_bweb_q, dm_bweb_d, dm_data_in_q, dm_data_in_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic                w_misalign, w_err;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_di;
`ifdef MISALIGN_SPLIT_EN
    logic                split_q, split_d;
    logic [DATA_W-1:0]   lo_q, lo_d, hi_bweb_q, hi_bweb_d, hi_di_q, hi_di_d;
    logic [7:0]          w_be8;
    logic [63:0]         w_di64;
    logic [DATA_W-1:0]   w_rd;
`endif

    // Byte-enable to active-low bit mask.
    function automatic logic [31:0] f_bweb(input logic [3:0] be);
        return {{8{~be[3]}}, {8{~be[2]}}, {8{~be[1]}}, {8{~be[0]}}};
    endfunction

    function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return {{24{b[7] & ~uns}}, b};
            2'b01:   return {{16{h[15] & ~uns}}, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef MISALIGN_SPLIT_EN
        // Only a split that would wrap past the last word is refused.
        w_err  = (req_size == 2'b11) || (w_misalign && (&req_addr[ADDR_W+1:2]));
        w_be8  = ((req_size == 2'b01) ? 8'h03 : 8'h0F) << req_addr[1:0];
        w_di64 = {32'd0, (req_size == 2'b01) ? {16'd0, req_wdata[15:0]} : req_wdata}
                 << {req_addr[1:0], 3'b000};
        w_rd   = 32'({dm_data_out, lo_q} >> {off_q, 3'b000});
`else
        w_err  = (req_size == 2'b11) || w_misalign;
`endif
        case (req_size)
            2'b00: begin
                w_be = 4'b0001 << req_addr[1:0];
                w_di = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be = req_addr[1] ? 4'b1100 : 4'b0011;
                w_di = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be = 4'hF;
                w_di = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        uns_d        = uns_q;
        size_d       = size_q;
        off_d        = off_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        dm_web_d     = 1'b1;
        dm_bweb_d    = '1;
        dm_addr_d    = dm_addr_q;
        dm_data_in_d = dm_data_in_q;
`ifdef MISALIGN_SPLIT_EN
        split_d      = split_q;
        lo_d         = lo_q;
        hi_bweb_d    = hi_bweb_q;
        hi_di_d      = hi_di_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    uns_d     = req_unsigned;
                    size_d    = req_size;
                    off_d     = req_addr[1:0];
                    dm_addr_d = req_addr[ADDR_W+1:2];
                    if (w_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_ISSUE;
                        dm_web_d = ~req_we;
`ifdef MISALIGN_SPLIT_EN
                        split_d   = w_misalign;
                        hi_bweb_d = f_bweb(w_be8[7:4]);
                        hi_di_d   = w_di64[63:32];
                        if (req_we) begin
                            dm_bweb_d    = w_misalign ? f_bweb(w_be8[3:0]) : f_bweb(w_be);
                            dm_data_in_d = w_misalign ? w_di64[31:0] : w_di;
                        end
`else
                        if (req_we) begin
                            dm_bweb_d    = f_bweb(w_be);
                            dm_data_in_d = w_di;
                        end
`endif
                    end
                end
            end
            ST_ISSUE: begin
`ifdef MISALIGN_SPLIT_EN
                if (split_q) begin
                    state_d   = ST_ISSUE1;
                    dm_addr_d = dm_addr_q + 1'b1;
                    dm_web_d  = ~we_q;
                    if (we_q) begin
                        dm_bweb_d    = hi_bweb_q;
                        dm_data_in_d = hi_di_q;
                    end
                end else if (we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
`else
                if (we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ST_ISSUE1: begin
                lo_d = dm_data_out;
                if (we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
`endif
            ST_WAIT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
`ifdef MISALIGN_SPLIT_EN
                rsp_rdata_d = split_q ? f_extract(w_rd, 2'b00, size_q, uns_q)
                                      : f_extract(dm_data_out, off_q, size_q, uns_q);
`else
                rsp_rdata_d = f_extract(dm_data_out, off_q, size_q, uns_q);
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            dm_web_q     <= 1'b1;
            dm_bweb_q    <= '1;
            dm_addr_q    <= '0;
            dm_data_in_q <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            lo_q         <= '0;
            hi_bweb_q    <= '1;
            hi_di_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            size_q       <= size_d;
            off_q        <= off_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            dm_web_q     <= dm_web_d;
            dm_bweb_q    <= dm_bweb_d;
            dm_addr_q    <= dm_addr_d;
            dm_data_in_q <= dm_data_in_d;
`ifdef MISALIGN_SPLIT_EN
            split_q      <= split_d;
            lo_q         <= lo_d;
            hi_bweb_q    <= hi_bweb_d;
            hi_di_q      <= hi_di_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign dm_web     = dm_web_q;
    assign dm_bweb    = dm_bweb_q;
    assign dm_addr    = dm_addr_q;
    assign dm_data_in = dm_data_in_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_unit.sv
// ============================================================================
// Module   : tb_dm_access_unit
// Purpose  : Self-checking bench for dm_access_unit: directed vector table,
//            reset/back-to-back sequences and random traffic vs a byte model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_access_unit;

    localparam int ADDR_W = 14;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              req_ready, rsp_valid, rsp_err, dm_web;
    logic [31:0]       rsp_rdata, dm_bweb, dm_data_in;
    logic [31:0]       dm_data_out = '0;
    logic [ADDR_W-1:0] dm_addr;

    dm_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dm_web(dm_web), .dm_bweb(dm_bweb), .dm_addr(dm_addr),
        .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
    );

    always #5 clk = ~clk;

    // SRAM stand-in: bit-masked write, registered read data.
    logic [31:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (!dm_web) sram[dm_addr] <= (sram[dm_addr] & dm_bweb) | (dm_data_in & ~dm_bweb);
        dm_data_out <= sram[dm_addr];
    end

    // Reference memory is a flat little-endian byte array.
    logic [7:0] ref_mem [0:65535];
    int n_vec = 0, n_err = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_web;
        logic [31:0] exp_bweb;
        logic [13:0] exp_daddr;
        logic [31:0] exp_di;
        logic [31:0] di_mask;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd, input logic err, input int lat,
                                input logic web, input logic [31:0] bweb, input logic [31:0] di);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat;
        v.exp_web = web; v.exp_bweb = bweb; v.exp_daddr = addr[15:2]; v.exp_di = di;
        v.di_mask = (we && !err) ? 32'hFFFF_FFFF : 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_web"}, 32'(dm_web), 32'd1);
        chk({tag, "_bweb"}, dm_bweb, 32'hFFFF_FFFF);
        chk({tag, "_daddr"}, 32'(dm_addr), 32'd0);
        chk({tag, "_di"}, dm_data_in, 32'd0);
    endtask

    // Spec-level outcome of one access; updates the byte model on stores.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [15:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat);
        int nb;
        bit misal;
        logic [31:0] v;
        nb = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
        misal = (int'(addr) % nb) != 0;
        rdata = '0;
        err = (size == SZ_X) || (misal && !SPLIT) || (misal && addr[15:2] == 14'h3FFF);
        lat = 1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[16'(int'(addr) + i)] = wdata[8*i +: 8];
            lat = misal ? 3 : 2;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[16'(int'(addr) + i)];
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            rdata = v;
            lat = misal ? 4 : 3;
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after RESP.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic web1, output logic [31:0] bweb1,
                          output logic [13:0] daddr1, output logic [31:0] di1);
        int wc;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
        req_wdata = wdata; req_valid = 1'b1;
        wc = 0;
        while (!req_ready && wc < 20) begin @(negedge clk); wc++; end
        chk("accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        web1 = dm_web; bweb1 = dm_bweb; daddr1 = dm_addr; di1 = dm_data_in;
        lat = 1;
        while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata; err = rsp_err;
        @(negedge clk);
        chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [15:0] addr, input logic [31:0] wdata);
        logic [31:0] erd, rd, bweb1, di1, ebweb, edi;
        logic eerr, err, web1;
        logic [13:0] da1;
        int elat, lat, nb;
        ref_access(we, size, uns, addr, wdata, erd, eerr, elat);
        do_req(we, size, uns, addr, wdata, rd, err, lat, web1, bweb1, da1, di1);
        chk("rdata", rd, erd);
        chk("err", 32'(err), 32'(eerr));
        chk("latency", 32'(lat), 32'(elat));
        chk("issue_web", 32'(web1), 32'(!(we && !eerr)));
        chk("issue_addr", 32'(da1), 32'(addr[15:2]));
        if (!(we && !eerr)) begin
            chk("issue_bweb_idle", bweb1, 32'hFFFF_FFFF);
        end else if (elat == 2) begin
            nb = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
            ebweb = 32'hFFFF_FFFF;
            for (int i = 0; i < nb; i++) ebweb[8*(int'(addr[1:0]) + i) +: 8] = 8'h00;
            edi = (size == SZ_B) ? {4{wdata[7:0]}} : (size == SZ_H) ? {2{wdata[15:0]}} : wdata;
            chk("issue_bweb_store", bweb1, ebweb);
            chk("issue_di_store", di1, edi);
        end
    endtask

    initial begin
        logic [31:0] t_rd, t_bweb, t_di, erd;
        logic        t_err, t_web, eerr, accepted;
        logic [13:0] t_da;
        int          t_lat, elat, idx, acc, nresp, cyc;
        logic [31:0] expq[$];
        logic [15:0] baddr [4];
        vec_t        v;

        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        tbl.push_back(mk(1, SZ_W, 0, 16'h0010, 32'hDEADBEEF, 0, 0, 2, 0, 32'h0000_0000, 32'hDEADBEEF));
        tbl.push_back(mk(1, SZ_B, 0, 16'h0013, 32'h0000_00A5, 0, 0, 2, 0, 32'h00FF_FFFF, 32'hA5A5A5A5));
        tbl.push_back(mk(0, SZ_B, 0, 16'h0013, 0, 32'hFFFF_FFA5, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_B, 1, 16'h0013, 0, 32'h0000_00A5, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(1, SZ_W, 0, 16'h0010, 32'h80017FFF, 0, 0, 2, 0, 32'h0000_0000, 32'h80017FFF));
        tbl.push_back(mk(0, SZ_H, 0, 16'h0012, 0, 32'hFFFF_8001, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_H, 0, 16'h0010, 0, 32'h0000_7FFF, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(1, SZ_W, 0, 16'h0010, 32'h33221100, 0, 0, 2, 0, 32'h0000_0000, 32'h33221100));
        tbl.push_back(mk(1, SZ_W, 0, 16'h0014, 32'h77665544, 0, 0, 2, 0, 32'h0000_0000, 32'h77665544));
`ifdef MISALIGN_SPLIT_EN
        tbl.push_back(mk(0, SZ_W, 0, 16'h0011, 0, 32'h44332211, 0, 4, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_H, 0, 16'h0013, 0, 32'h0000_4433, 0, 4, 1, 32'hFFFF_FFFF, 0));
`else
        tbl.push_back(mk(0, SZ_W, 0, 16'h0011, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_H, 0, 16'h0013, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0));
`endif
        tbl.push_back(mk(0, SZ_H, 1, 16'h0016, 0, 32'h0000_7766, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(1, SZ_H, 0, 16'h0012, 32'h1234BEEF, 0, 0, 2, 0, 32'h0000_FFFF, 32'hBEEFBEEF));
        tbl.push_back(mk(0, SZ_W, 0, 16'h0010, 0, 32'hBEEF1100, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_X, 0, 16'h0010, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(1, SZ_X, 0, 16'h0014, 32'hFFFF_FFFF, 0, 1, 1, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_W, 0, 16'h0014, 0, 32'h77665544, 0, 3, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_B, 0, 16'h0011, 0, 32'h0000_0011, 0, 3, 1, 32'hFFFF_FFFF, 0));
`ifdef MISALIGN_SPLIT_EN
        v = mk(1, SZ_H, 0, 16'h0011, 32'h1111CDAB, 0, 0, 3, 0, 32'hFF00_00FF, 32'h00CDAB00);
        v.di_mask = 32'h00FF_FF00;
        tbl.push_back(v);
        tbl.push_back(mk(0, SZ_W, 0, 16'h0010, 0, 32'hBECDAB00, 0, 4, 1, 32'hFFFF_FFFF, 0));
`else
        tbl.push_back(mk(1, SZ_H, 0, 16'h0011, 32'h1111CDAB, 0, 1, 1, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_W, 0, 16'h0010, 0, 32'hBEEF1100, 0, 3, 1, 32'hFFFF_FFFF, 0));
`endif
        tbl.push_back(mk(0, SZ_W, 0, 16'hFFFD, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, SZ_W, 0, 16'hFFFC, 0, 0, 0, 3, 1, 32'hFFFF_FFFF, 0));

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            ref_access(v.we, v.size, v.uns, v.addr, v.wdata, erd, eerr, elat);
            do_req(v.we, v.size, v.uns, v.addr, v.wdata, t_rd, t_err, t_lat, t_web, t_bweb, t_da, t_di);
            chk($sformatf("tbl%0d_rdata", k), t_rd, v.exp_rdata);
            chk($sformatf("tbl%0d_err", k), 32'(t_err), 32'(v.exp_err));
            chk($sformatf("tbl%0d_latency", k), 32'(t_lat), 32'(v.exp_lat));
            chk($sformatf("tbl%0d_web", k), 32'(t_web), 32'(v.exp_web));
            chk($sformatf("tbl%0d_bweb", k), t_bweb, v.exp_bweb);
            chk($sformatf("tbl%0d_daddr", k), 32'(t_da), 32'(v.exp_daddr));
            if (v.di_mask != 32'h0)
                chk($sformatf("tbl%0d_di", k), t_di & v.di_mask, v.exp_di & v.di_mask);
        end

        // Reset while a load sits in WAIT: dropped with no response.
        run_txn(1, SZ_W, 0, 16'h0020, 32'h12345678);
        req_we = 0; req_size = SZ_W; req_unsigned = 0; req_addr = 16'h0020; req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_reset("rst_in_wait");
        repeat (3) begin chk("rst_wait_no_rsp", 32'(rsp_valid), 32'd0); @(negedge clk); end
        run_txn(0, SZ_W, 0, 16'h0020, 0);

        // Reset on the accept edge: the store never happens.
        req_we = 1; req_size = SZ_W; req_addr = 16'h0020; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1; rst = 1'b1;
        @(negedge clk); req_valid = 1'b0; rst = 1'b0;
        repeat (3) begin
            chk("rst_store_web", 32'(dm_web), 32'd1);
            chk("rst_store_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        run_txn(0, SZ_W, 0, 16'h0020, 0);

        // Back-to-back loads with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            baddr[i] = 16'h0030 + 16'(4 * i);
            run_txn(1, SZ_W, 0, baddr[i], $urandom);
        end
        idx = 0; acc = 0; nresp = 0; cyc = 0;
        req_we = 0; req_size = SZ_W; req_unsigned = 0; req_addr = baddr[0]; req_valid = 1'b1;
        while ((acc < 4 || nresp < 4) && cyc < 60) begin
            if (rsp_valid) begin
                nresp++;
                if (expq.size() == 0) chk("b2b_extra_rsp", 32'(rsp_valid), 32'd0);
                else chk("b2b_rdata", rsp_rdata, expq.pop_front());
            end
            accepted = req_valid && req_ready;
            if (accepted) begin
                ref_access(0, SZ_W, 0, baddr[idx], 0, erd, eerr, elat);
                expq.push_back(erd);
                acc++; idx++;
            end
            @(negedge clk); cyc++;
            if (accepted) begin
                if (idx < 4) req_addr = baddr[idx];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd4);
        chk("b2b_responses", 32'(nresp), 32'd4);

        // Random traffic against the byte model.
        for (int t = 0; t < 200; t++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 15) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                             : 16'($urandom_range(0, 63));
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
